sram_async_ctrl: RTL and testbench

Request-side controller for the external 16-bit asynchronous SRAM (17-bit word address, active-low OE/WE/UB/LB strobes).
- Accepts single-word read/write requests on a valid/ready handshake.
- Sequences the SRAM strobes with parameterised cycle counts and returns read data with a one-cycle valid pulse.
- A top-level wrapper connects the sram_* ports to an sram_if instance; this block is the initiator on that interface.

---
 rtl/sram_ctrl_pkg.sv | 28 ++
 rtl/sram_wait_counter.sv | 30 +++
 rtl/sram_async_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sram_async_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the async SRAM controller.
// Provides bus widths, the controller state enum and small helpers.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_ctrl_state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Expand the two byte enables to a 16-bit lane mask.
  function automatic logic [SRAM_DATA_W-1:0] be_mask(logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with terminal-count flag (tc = count is zero).
// Ports: clk, reset_n, load, load_val -> tc. Counts down until zero.
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/sram_async_ctrl.sv
// Single-word request controller for a 16-bit async SRAM; all outputs registered.
// Ports: clk, reset_n, req_* (valid/ready), rsp_* (read data pulse), sram_* strobes/bus.
module sram_async_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_CYCLES   = 2,
  parameter int WR_CYCLES   = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_be,
  output logic                   rsp_valid,
  output logic [SRAM_DATA_W-1:0] rsp_rdata,
  output logic [SRAM_ADDR_W-1:0] sram_a,
  output logic [SRAM_DATA_W-1:0] sram_data_to_ram,
  input  logic [SRAM_DATA_W-1:0] sram_data_from_ram,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  if (RD_CYCLES < 1) begin : g_bad_rd
    $error("RD_CYCLES must be >= 1");
  end
  if (WR_CYCLES < 1) begin : g_bad_wr
    $error("WR_CYCLES must be >= 1");
  end
  if (TURN_CYCLES < 0) begin : g_bad_turn
    $error("TURN_CYCLES must be >= 0");
  end

  localparam int CW = $clog2(max3(RD_CYCLES, WR_CYCLES, TURN_CYCLES) + 1);
  localparam logic [CW-1:0] RD_LD   = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LD   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 1);

  sram_ctrl_state_t state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] a_q, a_d;
  logic [SRAM_DATA_W-1:0] dout_q, dout_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   ub_n_q, ub_n_d;
  logic                   lb_n_q, lb_n_d;
  logic [1:0]             be_q, be_d;
  logic                   cnt_load;
  logic [CW-1:0]          cnt_val;
  logic                   cnt_tc;

  sram_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    a_d         = a_q;
    dout_d      = dout_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    be_d        = be_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          a_d     = req_addr;
          be_d    = req_be;
          if (req_write) begin
            state_d = ST_WR_SETUP;
            dout_d  = req_wdata;
            ub_n_d  = ~req_be[1];
            lb_n_d  = ~req_be[0];
          end else begin
            // Both lanes are always read; be only masks the response.
            state_d  = ST_RD;
            oe_n_d   = 1'b0;
            ub_n_d   = 1'b0;
            lb_n_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = RD_LD;
          end
        end
      end
      ST_RD: begin
        if (cnt_tc) begin
          rsp_valid_d = 1'b1;
          rdata_d     = sram_data_from_ram & be_mask(be_q);
          oe_n_d      = 1'b1;
          ub_n_d      = 1'b1;
          lb_n_d      = 1'b1;
          if (TURN_CYCLES == 0) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d  = ST_TURN;
            cnt_load = 1'b1;
            cnt_val  = TURN_LD;
          end
        end
      end
      ST_TURN: begin
        if (cnt_tc) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        we_n_d   = 1'b0;
        cnt_load = 1'b1;
        cnt_val  = WR_LD;
      end
      ST_WR_PULSE: begin
        if (cnt_tc) begin
          state_d = ST_WR_HOLD;
          we_n_d  = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      a_q         <= '0;
      dout_q      <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      be_q        <= be_d;
    end
  end

  assign req_ready        = ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rdata_q;
  assign sram_a           = a_q;
  assign sram_data_to_ram = dout_q;
  assign sram_oe_n        = oe_n_q;
  assign sram_we_n        = we_n_q;
  assign sram_ub_n        = ub_n_q;
  assign sram_lb_n        = lb_n_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: default and swept-parameter instances,
// an SRAM array model and a word-level reference memory.
module tb_sram_async_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [16:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic [1:0]  ready_w, rspv_w, oe_w, we_w, ub_w, lb_w;
  logic [15:0] rdata_w [2];
  logic [16:0] a_w [2];
  logic [15:0] dto_w [2];
  logic [15:0] din;

  logic [15:0] sram_mem [0:131071];
  logic [15:0] ref_mem  [0:131071];

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int exp_rd, exp_wr, exp_turn;

  logic        m_ready, m_rspv, m_oe, m_we, m_ub, m_lb;
  logic [15:0] m_rdata, m_dto;
  logic [16:0] m_a;

  assign m_ready = ready_w[sel];
  assign m_rspv  = rspv_w[sel];
  assign m_oe    = oe_w[sel];
  assign m_we    = we_w[sel];
  assign m_ub    = ub_w[sel];
  assign m_lb    = lb_w[sel];
  assign m_rdata = rdata_w[sel];
  assign m_dto   = dto_w[sel];
  assign m_a     = a_w[sel];
  assign din     = sram_mem[m_a];

  sram_async_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid & ~sel), .req_ready(ready_w[0]),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rspv_w[0]), .rsp_rdata(rdata_w[0]),
    .sram_a(a_w[0]), .sram_data_to_ram(dto_w[0]),
    .sram_data_from_ram(din),
    .sram_oe_n(oe_w[0]), .sram_we_n(we_w[0]),
    .sram_ub_n(ub_w[0]), .sram_lb_n(lb_w[0])
  );

  sram_async_ctrl #(
    .RD_CYCLES(1), .WR_CYCLES(4), .TURN_CYCLES(0)
  ) dut_sweep (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid & sel), .req_ready(ready_w[1]),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rspv_w[1]), .rsp_rdata(rdata_w[1]),
    .sram_a(a_w[1]), .sram_data_to_ram(dto_w[1]),
    .sram_data_from_ram(din),
    .sram_oe_n(oe_w[1]), .sram_we_n(we_w[1]),
    .sram_ub_n(ub_w[1]), .sram_lb_n(lb_w[1])
  );

  // Async SRAM array: byte lanes written while we_n is low.
  always @(posedge clk) begin
    if (!m_we) begin
      if (!m_ub) sram_mem[m_a][15:8] <= m_dto[15:8];
      if (!m_lb) sram_mem[m_a][7:0]  <= m_dto[7:0];
    end
  end

  always @(negedge clk) begin
    if (reset_n && ((!oe_w[0] && !we_w[0]) || (!oe_w[1] && !we_w[1])))
      overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_sel(input logic s);
    sel      = s;
    exp_rd   = s ? 1 : 2;
    exp_wr   = s ? 4 : 2;
    exp_turn = s ? 0 : 1;
  endtask

  task automatic run_req(input logic wr, input logic [16:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic hold);
    int guard, rk, oe_cnt, we_cnt, we_first, rsp_cnt, rsp_k;
    logic [15:0] rsp_val, exp_data;
    logic        stable;
    logic [3:0]  end_strb;
    guard = 0; rk = -1; oe_cnt = 0; we_cnt = 0; we_first = -1;
    rsp_cnt = 0; rsp_k = -1; rsp_val = '0; stable = 1'b1;
    end_strb = '0;
    req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    req_valid = 1'b1;
    while (!m_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept", 32'(m_ready), 32'd1);
    if (!m_ready) begin
      req_valid = 1'b0;
      return;
    end
    exp_data = ref_mem[addr] & {{8{be[1]}}, {8{be[0]}}};
    if (wr) begin
      if (be[1]) ref_mem[addr][15:8] = wd[15:8];
      if (be[0]) ref_mem[addr][7:0]  = wd[7:0];
    end
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (!hold) req_valid = 1'b0;
        chk("strb_k0", 32'({m_ub, m_lb}),
            wr ? 32'({~be[1], ~be[0]}) : 32'd0);
      end
      if (!m_oe) oe_cnt++;
      if (!m_we) begin
        we_cnt++;
        if (we_first < 0) we_first = k;
      end
      if (m_rspv) begin
        rsp_cnt++;
        rsp_k = k;
        rsp_val = m_rdata;
      end
      if (m_a != addr) stable = 1'b0;
      if (wr && m_dto != wd) stable = 1'b0;
      if (m_ready) begin
        rk = k;
        end_strb = {m_oe, m_we, m_ub, m_lb};
        break;
      end
    end
    chk("addr_data_stable", 32'(stable), 32'd1);
    chk("strobes_idle", 32'(end_strb), 32'hF);
    if (wr) begin
      chk("wr_we_cycles", 32'(we_cnt), 32'(exp_wr));
      chk("wr_we_first", 32'(we_first), 32'd1);
      chk("wr_ready_back", 32'(rk), 32'(exp_wr + 2));
      chk("wr_no_rsp", 32'(rsp_cnt), 32'd0);
      chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
    end else begin
      chk("rd_oe_cycles", 32'(oe_cnt), 32'(exp_rd));
      chk("rd_rsp_count", 32'(rsp_cnt), 32'd1);
      chk("rd_rsp_time", 32'(rsp_k), 32'(exp_rd));
      chk("rd_data", 32'(rsp_val), 32'(exp_data));
      chk("rd_ready_back", 32'(rk), 32'(exp_rd + exp_turn));
      chk("rd_we_cycles", 32'(we_cnt), 32'd0);
    end
  endtask

  task automatic prefill();
    for (int i = 0; i < 16; i++)
      run_req(1'b1, 17'(i), 16'($urandom), 2'b11, 1'b0);
  endtask

  task automatic random_traffic(input int n);
    logic        wr, hold;
    logic [16:0] addr;
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 17'($urandom_range(0, 15));
      hold = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_req(wr, addr, 16'($urandom), 2'($urandom_range(0, 3)), hold);
    end
  endtask

  initial begin
    int guard, rsp_seen;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0;
    set_sel(1'b0);
    #12;
    chk("rst_ready", 32'(ready_w), 32'd0);
    chk("rst_rsp_valid", 32'(rspv_w), 32'd0);
    chk("rst_rdata", 32'(rdata_w[0]), 32'd0);
    chk("rst_addr", 32'(a_w[0]), 32'd0);
    chk("rst_wdata", 32'(dto_w[0]), 32'd0);
    chk("rst_strobes", 32'({oe_w, we_w, ub_w, lb_w}), 32'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(m_ready), 32'd1);

    run_req(1'b1, 17'h1ABCD, 16'hBEEF, 2'b11, 1'b0);
    run_req(1'b0, 17'h1ABCD, 16'h0000, 2'b11, 1'b0);
    run_req(1'b1, 17'h00010, 16'h1234, 2'b11, 1'b0);
    run_req(1'b0, 17'h00010, 16'h0000, 2'b11, 1'b0);
    run_req(1'b1, 17'h00020, 16'hFFFF, 2'b11, 1'b0);
    run_req(1'b1, 17'h00020, 16'hAA55, 2'b01, 1'b0);
    run_req(1'b0, 17'h00020, 16'h0000, 2'b11, 1'b0);
    run_req(1'b0, 17'h00020, 16'h0000, 2'b10, 1'b0);
    run_req(1'b1, 17'h00030, 16'hC3C3, 2'b11, 1'b0);
    run_req(1'b1, 17'h00030, 16'h0F0F, 2'b00, 1'b0);
    run_req(1'b0, 17'h00030, 16'h0000, 2'b00, 1'b0);
    run_req(1'b0, 17'h00030, 16'h0000, 2'b11, 1'b0);
    run_req(1'b0, 17'h00010, 16'h0000, 2'b11, 1'b1);
    run_req(1'b1, 17'h00020, 16'h5678, 2'b10, 1'b1);
    run_req(1'b0, 17'h00020, 16'h0000, 2'b11, 1'b0);
    prefill();
    random_traffic(24);

    @(negedge clk);
    set_sel(1'b1);
    @(negedge clk);
    run_req(1'b0, 17'h00010, 16'h0000, 2'b11, 1'b0);
    run_req(1'b1, 17'h00040, 16'h9ABC, 2'b11, 1'b1);
    run_req(1'b0, 17'h00040, 16'h0000, 2'b01, 1'b0);
    random_traffic(12);

    @(negedge clk);
    set_sel(1'b0);
    @(negedge clk);
    req_write = 1'b1; req_addr = 17'h1FFFF;
    req_wdata = 16'hDEAD; req_be = 2'b11; req_valid = 1'b1;
    guard = 0;
    while (!m_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_we_low", 32'(m_we), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_we_async", 32'(m_we), 32'd1);
    chk("rst_mid_strobes", 32'({m_oe, m_ub, m_lb}), 32'h7);
    chk("rst_mid_ready", 32'(m_ready), 32'd0);
    rsp_seen = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_first", 32'(m_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (m_rspv) rsp_seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
    run_req(1'b0, 17'h00010, 16'h0000, 2'b11, 1'b0);

    chk("oe_we_overlap", 32'(overlap), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
